// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM tile emulator.
// Accumulator sizing and output saturation live here.
package cim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    FINISH
  } tile_state_t;

  function automatic int acc_w(input int dw, input int xs);
    return 2 * dw + $clog2(xs);
  endfunction

  // Shift then clamp to a dw-bit signed range; caller keeps the low dw bits.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] acc,
    input int shift,
    input int dw
  );
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    sat_shift = sh;
    if (sh > hi) sat_shift = hi;
    else if (sh < lo) sat_shift = lo;
  endfunction

endpackage

// File: rtl/cim_mac_col.sv
// One crossbar column: signed multiply-accumulate over rows,
// then shift/saturate into the result register on load.
module cim_mac_col #(
  parameter int DW    = 8,
  parameter int ACC_W = 23,
  parameter int SHIFT = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          ld,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] w,
  output logic [DW-1:0] res
);
  import cim_pkg::*;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [DW-1:0]     res_q, res_d;
  logic signed [2*DW-1:0]   xs, ws, prod;
  logic signed [63:0]       acc_ext;
  logic        [DW-1:0]     sat;

  always_comb begin
    xs      = {{DW{x[DW-1]}}, x};
    ws      = {{DW{w[DW-1]}}, w};
    prod    = xs * ws;
    acc_ext = {{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    sat     = DW'(sat_shift(acc_ext, SHIFT, DW));
    acc_d   = acc_q;
    if (clr) acc_d = '0;
    else if (en)
      acc_d = acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    res_d = ld ? sat : res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: rtl/cim_tile_emu.sv
// Behavioural crossbar CIM tile: input buffer, weight memory,
// row-serial MVM across all columns, registered result readback.
module cim_tile_emu #(
  parameter int DATATYPE_SIZE = 8,
  parameter int XBAR_SIZE     = 128,
  parameter int N_COLS        = XBAR_SIZE / DATATYPE_SIZE,
  parameter int OUT_SHIFT     = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [$clog2(XBAR_SIZE)-1:0] i_wr_addr,
  input  logic [DATATYPE_SIZE-1:0]     i_wr_data,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_done,
  input  logic [$clog2(XBAR_SIZE)-1:0] i_rd_addr,
  output logic [DATATYPE_SIZE-1:0]     o_rd_data,
  input  logic                         i_w_we,
  input  logic [$clog2(XBAR_SIZE)-1:0] i_w_row,
  input  logic [$clog2(N_COLS)-1:0]    i_w_col,
  input  logic [DATATYPE_SIZE-1:0]     i_w_data
);
  import cim_pkg::*;

  localparam int DW    = DATATYPE_SIZE;
  localparam int AW    = $clog2(XBAR_SIZE);
  localparam int CW    = $clog2(N_COLS);
  localparam int ACC_W = acc_w(DW, XBAR_SIZE);
  localparam logic [AW:0] LAST_ROW = (AW+1)'(XBAR_SIZE - 1);
  localparam logic [AW:0] COLS_A   = (AW+1)'(N_COLS);
  localparam logic [CW:0] COLS_C   = (CW+1)'(N_COLS);

  tile_state_t state_q, state_d;
  logic [AW:0]   row_q, row_d;
  logic [DW-1:0] rd_q, rd_d;
  logic [AW-1:0] row_idx;

  logic [DW-1:0] ibuf_q [XBAR_SIZE];
  logic [DW-1:0] wmem_q [XBAR_SIZE][N_COLS];
  logic [DW-1:0] res_arr [N_COLS];

  logic idle, ibuf_we, wmem_we;
  logic mac_clr, mac_en, mac_ld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = COMPUTE;
          row_d   = '0;
        end
      end
      COMPUTE: begin
        row_d = row_q + (AW+1)'(1);
        if (row_q == LAST_ROW) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writes and start only land while idle; anything else is dropped.
  always_comb begin
    idle    = (state_q == IDLE);
    o_busy  = !idle;
    o_done  = (state_q == FINISH);
    ibuf_we = idle && i_wr_en && !rst;
    wmem_we = idle && i_w_we && !rst && ({1'b0, i_w_col} < COLS_C);
    mac_clr = idle && i_start;
    mac_en  = (state_q == COMPUTE);
    mac_ld  = (state_q == FINISH);
  end

  always_comb begin
    row_idx = row_q[AW-1:0];
    rd_d    = '0;
    if ({1'b0, i_rd_addr} < COLS_A)
      rd_d = res_arr[i_rd_addr[CW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (ibuf_we) ibuf_q[i_wr_addr] <= i_wr_data;
    if (wmem_we) wmem_q[i_w_row][i_w_col] <= i_w_data;
  end

  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    cim_mac_col #(
      .DW   (DW),
      .ACC_W(ACC_W),
      .SHIFT(OUT_SHIFT)
    ) u_col (
      .clk(clk),
      .rst(rst),
      .clr(mac_clr),
      .en (mac_en),
      .ld (mac_ld),
      .x  (ibuf_q[row_idx]),
      .w  (wmem_q[row_idx][c]),
      .res(res_arr[c])
    );
  end

  assign o_rd_data = rd_q;

endmodule

// File: tb/tb_cim_tile_emu.sv
// Scoreboard bench: two tiles (shift 0 and 7) share stimulus and are
// checked against a plain-arithmetic MVM model.
module tb_cim_tile_emu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       wr_en = 0, start = 0, w_we = 0;
  logic [6:0] wr_addr = 0, rd_addr = 0, w_row = 0;
  logic [7:0] wr_data = 0, w_data = 0;
  logic [3:0] w_col = 0;
  logic       busy0, done0, busy7, done7;
  logic [7:0] rd0, rd7;

  cim_tile_emu #(.OUT_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_start(start), .o_busy(busy0),
    .o_done(done0), .i_rd_addr(rd_addr), .o_rd_data(rd0),
    .i_w_we(w_we), .i_w_row(w_row), .i_w_col(w_col), .i_w_data(w_data)
  );

  cim_tile_emu #(.OUT_SHIFT(7)) dut7 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_start(start), .o_busy(busy7),
    .o_done(done7), .i_rd_addr(rd_addr), .o_rd_data(rd7),
    .i_w_we(w_we), .i_w_row(w_row), .i_w_col(w_col), .i_w_data(w_data)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit rd_req = 0;
  bit rd_chk = 0;

  int exp_done_cyc[$];
  int exp_rd0[$];
  int exp_rd7[$];

  int ib[128];
  int wm[128][16];
  int cur0[16], cur7[16], pend0[16], pend7[16];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_chk <= rd_req;
  end

  // Monitor: done timing, busy length, busy drop, read data.
  int busy_run = 0;
  bit prev_done = 0;
  initial forever begin
    @(negedge clk);
    if (rst) busy_run = 0;
    else if (busy0) busy_run++;
    else busy_run = 0;
    if (prev_done) begin
      tests++;
      if (busy0 || busy7 || done0 || done7) begin
        fails++;
        $display("FAIL busy_drop cyc=%0d busy0=%0b busy7=%0b want 0",
                 cyc, busy0, busy7);
      end
    end
    prev_done = done0;
    if (done0 || done7) begin
      tests++;
      if (exp_done_cyc.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done cyc=%0d done0=%0b done7=%0b",
                 cyc, done0, done7);
      end else begin
        int e;
        e = exp_done_cyc.pop_front();
        if (!(done0 && done7) || cyc != e || busy_run != 129 || !busy7) begin
          fails++;
          $display("FAIL done_timing cyc=%0d want %0d busy_run=%0d want 129",
                   cyc, e, busy_run);
        end
      end
    end
    if (rd_chk) begin
      int e0, e7;
      tests++;
      e0 = exp_rd0.pop_front();
      e7 = exp_rd7.pop_front();
      if ($signed(rd0) != e0 || $signed(rd7) != e7) begin
        fails++;
        $display("FAIL read cyc=%0d got %0d/%0d want %0d/%0d",
                 cyc, $signed(rd0), $signed(rd7), e0, e7);
      end
    end
  end

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic void calc();
    for (int c = 0; c < 16; c++) begin
      int acc;
      acc = 0;
      for (int r = 0; r < 128; r++) acc += ib[r] * wm[r][c];
      pend0[c] = sat8(acc);
      pend7[c] = sat8(acc >>> 7);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_in(input int a, input int d);
    wr_en = 1; wr_addr = 7'(a); wr_data = 8'(d);
    ib[a] = d;
    tick();
    wr_en = 0;
  endtask

  task automatic put_w(input int r, input int c, input int d);
    w_we = 1; w_row = 7'(r); w_col = 4'(c); w_data = 8'(d);
    wm[r][c] = d;
    tick();
    w_we = 0;
  endtask

  task automatic do_read(input int a);
    rd_addr = 7'(a);
    rd_req = 1;
    exp_rd0.push_back(a < 16 ? cur0[a] : 0);
    exp_rd7.push_back(a < 16 ? cur7[a] : 0);
    tick();
    rd_req = 0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) do_read(a);
    do_read(20);
    do_read(127);
  endtask

  task automatic start_run(input bit with_wr, input int a, input int d);
    if (with_wr) begin
      wr_en = 1; wr_addr = 7'(a); wr_data = 8'(d);
      ib[a] = d;
    end
    start = 1;
    exp_done_cyc.push_back(cyc + 129);
    calc();
    tick();
    start = 0;
    wr_en = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (done0) break;
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL done_timeout after %0d cycles want done", n);
      exp_done_cyc.delete();
    end
    tick();
    cur0 = pend0;
    cur7 = pend7;
  endtask

  task automatic rand_round(input int lo, input int hi);
    for (int r = 0; r < 128; r++)
      put_in(r, lo + int'($urandom_range(hi - lo)));
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 16; c++)
        put_w(r, c, lo + int'($urandom_range(hi - lo)));
    start_run(1, int'($urandom_range(127)), lo + int'($urandom_range(hi - lo)));
    repeat (5) do_read(int'($urandom_range(31)));
    wait_done();
    read_all();
  endtask

  initial begin
    for (int c = 0; c < 16; c++) begin
      cur0[c] = 0; cur7[c] = 0;
    end
    repeat (3) tick();
    rst = 0;
    tests++;
    if (busy0 || done0 || busy7 || done7 || rd0 != 0 || rd7 != 0) begin
      fails++;
      $display("FAIL reset_state busy=%0b done=%0b rd=%0d want 0 0 0",
               busy0, done0, rd0);
    end
    do_read(0); do_read(5); do_read(15); do_read(20); do_read(127);

    // identity-like columns
    for (int r = 0; r < 128; r++) put_in(r, 1);
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 16; c++)
        put_w(r, c, c == 0 ? 1 : (c == 1 ? -1 : 0));
    start_run(0, 0, 0);
    do_read(0); do_read(1);
    wait_done();
    read_all();

    // exact small value; start shares a cycle with an input write
    for (int r = 0; r < 128; r++) put_in(r, 0);
    put_in(0, 5);
    put_w(0, 2, 4);
    put_w(1, 2, 6);
    start_run(1, 1, -3);
    wait_done();
    read_all();

    // shift and saturation, positive then negative
    for (int r = 0; r < 128; r++) put_in(r, 127);
    for (int r = 0; r < 128; r++) put_w(r, 3, 127);
    start_run(0, 0, 0);
    wait_done();
    read_all();
    for (int r = 0; r < 128; r++) put_w(r, 3, -127);
    start_run(0, 0, 0);
    wait_done();
    read_all();

    // writes and start during compute are dropped
    start_run(0, 0, 0);
    repeat (20) tick();
    wr_en = 1; wr_addr = 0; wr_data = 8'd99;
    w_we = 1; w_row = 0; w_col = 3; w_data = 8'd55;
    start = 1;
    tick();
    wr_en = 0; w_we = 0; start = 0;
    do_read(3);
    wait_done();
    read_all();
    start_run(0, 0, 0);
    wait_done();
    read_all();

    // reset aborts compute at row 50
    start_run(0, 0, 0);
    repeat (51) tick();
    rst = 1;
    exp_done_cyc.delete();
    tick();
    tests++;
    if (busy0 || busy7) begin
      fails++;
      $display("FAIL abort_busy busy0=%0b busy7=%0b want 0", busy0, busy7);
    end
    rst = 0;
    for (int c = 0; c < 16; c++) begin
      cur0[c] = 0; cur7[c] = 0;
    end
    do_read(2); do_read(3); do_read(0);
    repeat (140) tick();
    start_run(0, 0, 0);
    wait_done();
    read_all();

    rand_round(-128, 127);
    rand_round(-8, 7);
    rand_round(-128, 127);

    repeat (4) tick();
    tests++;
    if (exp_done_cyc.size() != 0 || exp_rd0.size() != 0) begin
      fails++;
      $display("FAIL drain done_q=%0d rd_q=%0d want 0 0",
               exp_done_cyc.size(), exp_rd0.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
